// File: rtl/adam_obi_pkg.sv
// ---------------------------------------------------------------------------
// adam_obi_pkg
// Shared types and helpers for the OBI arbiter slice.
//   - pause_state_e : pause handshake FSM states (RUN, DRAIN, PAUSED)
//   - clog2_min1()  : index width helper that never returns zero. Use it for
//                     requester-ID (ID_T) and FIFO pointer widths.
// ---------------------------------------------------------------------------
package adam_obi_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    PAUSED = 2'd2
  } pause_state_e;

  // A single-entry structure still needs one index bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adam_id_fifo.sv
// ---------------------------------------------------------------------------
// adam_id_fifo
// Synchronous FIFO of requester IDs. It holds one entry per outstanding OBI
// transaction so that responses can be steered back in order.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i, data_i write an ID. The write is ignored when the FIFO is full.
//   pop_i          drop the head entry. The pop is ignored when the FIFO is
//                  empty.
//   head_o         oldest ID
//   full_o, empty_o, count_o   occupancy status
// A push and a pop in the same cycle are both honoured.
// ---------------------------------------------------------------------------
module adam_id_fifo
  import adam_obi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap explicitly, so any DEPTH works, including DEPTH == 1.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset. The empty flag masks any stale contents.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/adam_obi_arbiter.sv
// ---------------------------------------------------------------------------
// adam_obi_arbiter
// Shares one OBI master port between NO_REQS OBI requesters.
//   - Round-robin arbitration. A request that has been presented but not yet
//     granted is locked, so it stays stable on the shared port.
//   - Responses are routed in order through an ID FIFO of outstanding
//     transactions (at most MAX_TRANS).
//   - A pause slave drains in-flight transactions before it acknowledges.
// Configuration macro: ADAM_OBI_ARBITER_FIXED_PRIO_EN
//   When this macro is defined, arbitration uses fixed priority and the
//   lowest index wins.
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   pause_req_i, pause_ack_o        pause handshake
//   req_i/gnt_o/addr_i/we_i/be_i/wdata_i  per-requester OBI request channel
//                                         (packed, port k at slice k)
//   rvalid_o/rready_i/rdata_o       per-requester response channel
//                                   (rdata_o is broadcast)
//   req_o/gnt_i/addr_o/we_o/be_o/wdata_o  shared OBI request channel
//   rvalid_i/rready_o/rdata_i       shared response channel
// Upstream requesters must be reset together with this block, because reset
// discards the outstanding-ID FIFO.
// ---------------------------------------------------------------------------
module adam_obi_arbiter
  import adam_obi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH/8,
  parameter int unsigned NO_REQS    = 2,
  parameter int unsigned MAX_TRANS  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,

  input  logic                          pause_req_i,
  output logic                          pause_ack_o,

  input  logic [NO_REQS-1:0]            req_i,
  output logic [NO_REQS-1:0]            gnt_o,
  input  logic [NO_REQS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NO_REQS-1:0]            we_i,
  input  logic [NO_REQS*STRB_WIDTH-1:0] be_i,
  input  logic [NO_REQS*DATA_WIDTH-1:0] wdata_i,
  output logic [NO_REQS-1:0]            rvalid_o,
  input  logic [NO_REQS-1:0]            rready_i,
  output logic [NO_REQS*DATA_WIDTH-1:0] rdata_o,

  output logic                          req_o,
  input  logic                          gnt_i,
  output logic [ADDR_WIDTH-1:0]         addr_o,
  output logic                          we_o,
  output logic [STRB_WIDTH-1:0]         be_o,
  output logic [DATA_WIDTH-1:0]         wdata_o,
  input  logic                          rvalid_i,
  output logic                          rready_o,
  input  logic [DATA_WIDTH-1:0]         rdata_i
);

  localparam int unsigned ID_W  = clog2_min1(NO_REQS);
  localparam int unsigned CNT_W = $clog2(MAX_TRANS+1);

  typedef logic [ID_W-1:0] id_t;

  pause_state_e state_q, state_d;
  logic         lock_q, lock_d;
  id_t          locked_id_q, locked_id_d;
  id_t          rr_ptr;
  id_t          sel;
  id_t          head;
  logic         can_issue;
  logic         accept;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // A locked request keeps ownership of the shared port. Otherwise the
  // first active requester at or after the pointer wins, wrapping around.
  always_comb begin
    logic found;
    int   idx;
    sel   = rr_ptr;
    found = 1'b0;
    idx   = 0;
    if (lock_q) begin
      sel = locked_id_q;
    end else begin
      for (int i = 0; i < int'(NO_REQS); i++) begin
        idx = int'(rr_ptr) + i;
        if (idx >= int'(NO_REQS)) begin
          idx = idx - int'(NO_REQS);
        end
        if (!found && req_i[idx]) begin
          sel   = id_t'(idx);
          found = 1'b1;
        end
      end
    end
  end

  // Only a locked request may still issue while draining. A full FIFO
  // blocks issue even in a cycle where a pop frees an entry.
  assign can_issue = ((state_q == RUN) || lock_q) && !fifo_full;
  assign req_o     = req_i[sel] && can_issue;
  assign accept    = req_o && gnt_i;

  assign addr_o  = addr_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign we_o    = we_i[sel];
  assign be_o    = be_i[sel*STRB_WIDTH +: STRB_WIDTH];
  assign wdata_o = wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];

  // Grants pass straight through to the selected requester, and responses
  // go to the requester at the FIFO head.
  always_comb begin
    gnt_o          = '0;
    gnt_o[sel]     = accept;
    rvalid_o       = '0;
    rvalid_o[head] = rvalid_i && !fifo_empty;
  end

  assign rready_o = rready_i[head] && !fifo_empty;
  assign pop      = rvalid_i && rready_o;
  assign rdata_o  = {NO_REQS{rdata_i}};

  // A request that is presented but not granted holds the port until it is
  // granted, so the OBI request stays stable across arbitration.
  always_comb begin
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    if (req_o && !gnt_i) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end else if (accept) begin
      lock_d = 1'b0;
    end
  end

`ifdef ADAM_OBI_ARBITER_FIXED_PRIO_EN
  // Scanning always starts at index 0, which gives fixed lowest-index priority.
  assign rr_ptr = '0;
`else
  id_t rr_ptr_q, rr_ptr_d;

  // After each accept, the requester after the winner gets first claim.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (sel == id_t'(NO_REQS-1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // Pause handshake. The block acknowledges only when nothing is locked and
  // nothing is outstanding. Dropping the request while draining resumes
  // normal operation without ever acknowledging.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (pause_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pause_req_i) begin
          state_d = RUN;
        end else if (!lock_q && (fifo_count == '0)) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (!pause_req_i) state_d = RUN;
      end
      default: state_d = PAUSED;
    endcase
  end

  assign pause_ack_o = (state_q == PAUSED);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= PAUSED;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
    end
  end

  adam_id_fifo #(
    .DEPTH (MAX_TRANS),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding is a downstream protocol error.
  // Such a response is ignored, because rready_o stays low.
  assert property (@(posedge clk_i) disable iff (rst_i) !(rvalid_i && fifo_empty));
`endif

endmodule

// File: tb/tb_adam_obi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adam_obi_arbiter
// Directed testbench for adam_obi_arbiter (NO_REQS=2, MAX_TRANS=4). It covers
// reset, arbitration order, the lock, the full limit, response routing and
// the pause drain. The bench adjusts its grant expectations when
// ADAM_OBI_ARBITER_FIXED_PRIO_EN is defined.
// ---------------------------------------------------------------------------
module tb_adam_obi_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        pauseReq;
  logic        pauseAck;
  logic [1:0]  reqIn;
  logic [1:0]  gntOut;
  logic [63:0] addrIn;
  logic [1:0]  weIn;
  logic [7:0]  beIn;
  logic [63:0] wdataIn;
  logic [1:0]  rvalidOut;
  logic [1:0]  rreadyIn;
  logic [63:0] rdataOut;
  logic        reqOut;
  logic        gntIn;
  logic [31:0] addrOut;
  logic        weOut;
  logic [3:0]  beOut;
  logic [31:0] wdataOut;
  logic        rvalidIn;
  logic        rreadyOut;
  logic [31:0] rdataIn;

  int checkCount = 0;
  int errorCount = 0;

  logic [1:0]  expGrant [4];
  logic [1:0]  expResume;
  logic [31:0] respData [4];

  always #5 clock = ~clock;

  adam_obi_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STRB_WIDTH (4),
    .NO_REQS    (2),
    .MAX_TRANS  (4)
  ) dut (
    .clk_i       (clock),
    .rst_i       (reset),
    .pause_req_i (pauseReq),
    .pause_ack_o (pauseAck),
    .req_i       (reqIn),
    .gnt_o       (gntOut),
    .addr_i      (addrIn),
    .we_i        (weIn),
    .be_i        (beIn),
    .wdata_i     (wdataIn),
    .rvalid_o    (rvalidOut),
    .rready_i    (rreadyIn),
    .rdata_o     (rdataOut),
    .req_o       (reqOut),
    .gnt_i       (gntIn),
    .addr_o      (addrOut),
    .we_o        (weOut),
    .be_o        (beOut),
    .wdata_o     (wdataOut),
    .rvalid_i    (rvalidIn),
    .rready_o    (rreadyOut),
    .rdata_i     (rdataIn)
  );

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock, drive this cycle's inputs, then let the logic settle.
  task automatic applyStimulus(input logic [1:0] req, input logic gnt,
                               input logic rvalid, input logic [1:0] rready,
                               input logic [31:0] rdata);
    @(posedge clock);
    #1;
    reqIn    = req;
    gntIn    = gnt;
    rvalidIn = rvalid;
    rreadyIn = rready;
    rdataIn  = rdata;
    #1;
  endtask

  // Stop the run if the main sequence does not finish in time.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: sequence did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
`ifdef ADAM_OBI_ARBITER_FIXED_PRIO_EN
    expGrant  = '{2'b01, 2'b01, 2'b01, 2'b01};
    expResume = 2'b01;
`else
    expGrant  = '{2'b01, 2'b10, 2'b01, 2'b10};
    expResume = 2'b10;
`endif
    respData = '{32'hA, 32'hB, 32'hC, 32'hD};

    reset    = 1'b1;
    pauseReq = 1'b0;
    reqIn    = '0;
    gntIn    = 1'b0;
    rvalidIn = 1'b0;
    rreadyIn = '0;
    rdataIn  = '0;
    addrIn   = {32'h0000_2000, 32'h0000_1000};
    weIn     = 2'b10;
    beIn     = {4'hC, 4'h3};
    wdataIn  = {32'hBBBB_0001, 32'hAAAA_0000};

    // Reset state
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    checkOutput("rstAck", pauseAck, 1);
    checkOutput("rstReqOut", reqOut, 0);
    checkOutput("rstGnt", gntOut, 0);
    checkOutput("rstRvalid", rvalidOut, 0);
    checkOutput("rstRready", rreadyOut, 0);

    reset = 1'b0;
    #1;
    checkOutput("ackBeforeFirstEdge", pauseAck, 1);
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    checkOutput("ackDropped", pauseAck, 0);

    // Both requesters held, four grants fill the ID FIFO
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
      checkOutput($sformatf("grant%0d", i), gntOut, expGrant[i]);
      checkOutput($sformatf("reqOut%0d", i), reqOut, 1);
      checkOutput($sformatf("addr%0d", i), addrOut,
                  (expGrant[i] == 2'b01) ? 32'h1000 : 32'h2000);
      if (i == 0) begin
        checkOutput("we0", weOut, 0);
        checkOutput("be0", beOut, 4'h3);
        checkOutput("wdata0", wdataOut, 32'hAAAA_0000);
      end
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
    checkOutput("fullReqOut", reqOut, 0);
    checkOutput("fullGnt", gntOut, 0);

    // Head requester not ready, so no pop happens
    applyStimulus(2'b00, 1'b0, 1'b1, ~expGrant[0], 32'hA);
    checkOutput("stallRvalid", rvalidOut, expGrant[0]);
    checkOutput("stallRready", rreadyOut, 0);

    // First pop while full: accept is still blocked this cycle
    applyStimulus(2'b11, 1'b1, 1'b1, 2'b11, respData[0]);
    checkOutput("resp0Rvalid", rvalidOut, expGrant[0]);
    checkOutput("resp0Rready", rreadyOut, 1);
    checkOutput("resp0Rdata", rdataOut, {respData[0], respData[0]});
    checkOutput("popFullReqOut", reqOut, 0);
    checkOutput("popFullGnt", gntOut, 0);

    for (int i = 1; i < 4; i++) begin
      applyStimulus(2'b00, 1'b0, 1'b1, 2'b11, respData[i]);
      checkOutput($sformatf("resp%0dRvalid", i), rvalidOut, expGrant[i]);
      checkOutput($sformatf("resp%0dRready", i), rreadyOut, 1);
      checkOutput($sformatf("resp%0dRdata", i), rdataOut, {respData[i], respData[i]});
    end
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b11, 32'h0);
    checkOutput("emptyRvalid", rvalidOut, 0);
    checkOutput("emptyRready", rreadyOut, 0);

    // Lock: requester 1 waits for grant while requester 0 joins
    applyStimulus(2'b10, 1'b0, 1'b0, 2'b00, 32'h0);
    checkOutput("lock0ReqOut", reqOut, 1);
    checkOutput("lock0Addr", addrOut, 32'h2000);
    checkOutput("lock0Gnt", gntOut, 0);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(2'b11, 1'b0, 1'b0, 2'b00, 32'h0);
      checkOutput($sformatf("lock%0dAddr", i), addrOut, 32'h2000);
      checkOutput($sformatf("lock%0dGnt", i), gntOut, 0);
    end
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
    checkOutput("lockGrant", gntOut, 2'b10);
    checkOutput("lockGrantAddr", addrOut, 32'h2000);
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
    checkOutput("afterLockGrant", gntOut, 2'b01);
    checkOutput("afterLockAddr", addrOut, 32'h1000);

    // Pause with two outstanding transactions (IDs 1 then 0)
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    pauseReq = 1'b1;
    checkOutput("pauseReqAck", pauseAck, 0);
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
    checkOutput("drainReqOut", reqOut, 0);
    checkOutput("drainGnt", gntOut, 0);
    checkOutput("drainAck", pauseAck, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 2'b11, 32'h55);
    checkOutput("drainPop0Rvalid", rvalidOut, 2'b10);
    checkOutput("drainPop0Ack", pauseAck, 0);
    applyStimulus(2'b00, 1'b0, 1'b1, 2'b11, 32'h66);
    checkOutput("drainPop1Rvalid", rvalidOut, 2'b01);
    checkOutput("drainPop1Ack", pauseAck, 0);
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
    checkOutput("ackAfterLastPop", pauseAck, 0);
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
    checkOutput("ackRaised", pauseAck, 1);
    checkOutput("pausedReqOut", reqOut, 0);
    pauseReq = 1'b0;
    #1;
    checkOutput("ackHeldOnRelease", pauseAck, 1);
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b00, 32'h0);
    checkOutput("ackDroppedResume", pauseAck, 0);
    checkOutput("resumeReqOut", reqOut, 1);
    checkOutput("resumeGrant", gntOut, expResume);
    applyStimulus(2'b00, 1'b0, 1'b0, 2'b00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
